// File: rtl/hs_cdc_fifo_pkg.sv
// Shared types and helpers for the async FIFO write/read controllers.
package hs_cdc_fifo_pkg;

  // Write-side controller states.
  typedef enum logic {WR_ST_INIT, WR_ST_RUN} hs_cdc_fifo_wr_state_t;

  // Widest pointer supported (ADDR_WIDTH up to 16, plus the wrap bit).
  localparam int PTR_MAX_W = 17;

  // Modular pointer distance wr - rd, reduced to the low 'width' bits.
  function automatic logic [PTR_MAX_W-1:0] ptr_diff(
    input logic [PTR_MAX_W-1:0] wr,
    input logic [PTR_MAX_W-1:0] rd,
    input int                   width
  );
    logic [PTR_MAX_W-1:0] mask;
    mask = (PTR_MAX_W'(1) << width) - PTR_MAX_W'(1);
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/hs_cdc_fifo_level_calc.sv
// Combinational pointer-distance compare: fill level plus depth/threshold/
// overflow flags. Reused by the read-side controller for its own status.
module hs_cdc_fifo_level_calc
  import hs_cdc_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int THRESH     = 12
) (
  input  logic [ADDR_WIDTH:0] wr_ptr,
  input  logic [ADDR_WIDTH:0] rd_ptr,
  output logic [ADDR_WIDTH:0] diff,
  output logic                at_depth,
  output logic                at_thresh,
  output logic                over_depth
);

  localparam logic [ADDR_WIDTH:0] DEPTH_V  = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] THRESH_V = (ADDR_WIDTH+1)'(THRESH);

  // Distance modulo the pointer range, then compare against the fixed limits.
  always_comb begin
    diff       = (ADDR_WIDTH+1)'(ptr_diff(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr), ADDR_WIDTH + 1));
    at_depth   = (diff == DEPTH_V);
    at_thresh  = (diff >= THRESH_V);
    over_depth = (diff > DEPTH_V);
  end

endmodule

// File: rtl/hs_cdc_fifo_wr_ctrl.sv
// Write-side control for the async FIFO: accepts a valid/ready stream, drives
// the RAM write port, owns the binary write pointer and derives full/afull/
// level/overflow from the read pointer already synchronized into clk.
module hs_cdc_fifo_wr_ctrl
  import hs_cdc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12,
  parameter int INIT_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic [ADDR_WIDTH:0]   rd_ptr_synced,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  afull,
  output logic                  err_ovf
);

  localparam logic [ADDR_WIDTH:0] DEPTH_V   = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [7:0]          INIT_LAST = 8'(INIT_CYCLES - 1);

  hs_cdc_fifo_wr_state_t state, state_next;
  logic [7:0]            init_cnt;
  logic                  xfer;
  logic [ADDR_WIDTH:0]   wr_ptr_next;
  logic [ADDR_WIDTH:0]   diff_next;
  logic [ADDR_WIDTH:0]   level_next;
  logic                  at_depth, at_thresh, over_depth;

  // Write port: s_ready is registered, so a transfer can never pass full.
  always_comb begin
    xfer        = s_valid & s_ready;
    mem_we      = xfer;
    mem_waddr   = wr_ptr[ADDR_WIDTH-1:0];
    mem_wdata   = s_data;
    wr_ptr_next = wr_ptr + (ADDR_WIDTH+1)'(xfer);
  end

  // INIT holds s_ready low long enough for the read-side syncer to settle.
  always_comb begin
    state_next = state;
    if (state == WR_ST_INIT && init_cnt == INIT_LAST) begin
      state_next = WR_ST_RUN;
    end
  end

  hs_cdc_fifo_level_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .THRESH     (AFULL_THRESH)
  ) u_level_calc (
    .wr_ptr     (wr_ptr_next),
    .rd_ptr     (rd_ptr_synced),
    .diff       (diff_next),
    .at_depth   (at_depth),
    .at_thresh  (at_thresh),
    .over_depth (over_depth)
  );

  // An impossible distance means a corrupted pointer; clamp to full.
  always_comb begin
    level_next = over_depth ? DEPTH_V : diff_next;
  end

  // FSM and init counter.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state    <= WR_ST_INIT;
      init_cnt <= 8'd0;
    end else begin
      state <= state_next;
      if (state == WR_ST_INIT) begin
        init_cnt <= init_cnt + 8'd1;
      end
    end
  end

  // Pointer, status flags and registered ready, all from the next-state distance.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr  <= '0;
      level   <= '0;
      full    <= 1'b0;
      afull   <= 1'b0;
      s_ready <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_next;
      level   <= level_next;
      full    <= at_depth | over_depth;
      afull   <= at_thresh;
      s_ready <= (state_next == WR_ST_RUN) & ~at_depth & ~over_depth;
      err_ovf <= err_ovf | over_depth;
    end
  end

endmodule

// File: tb/tb_hs_cdc_fifo_wr_ctrl.sv
// Scoreboard bench for hs_cdc_fifo_wr_ctrl: stimulus pushes expected writes
// and status snapshots; a negedge monitor pops and compares.
module tb_hs_cdc_fifo_wr_ctrl;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        mem_we;
  logic [3:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [4:0]  wr_ptr;
  logic [4:0]  rd_ptr_synced = '0;
  logic [4:0]  level;
  logic        full, afull, err_ovf;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] wp;
    logic [4:0] lvl;
    logic       full;
    logic       afull;
    logic       rdy;
    logic       err;
    string      name;
  } st_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  st_t st_q[$];
  wr_t wr_q[$];

  hs_cdc_fifo_wr_ctrl #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (4),
    .AFULL_THRESH (12),
    .INIT_CYCLES  (4)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .wr_ptr        (wr_ptr),
    .rd_ptr_synced (rd_ptr_synced),
    .level         (level),
    .full          (full),
    .afull         (afull),
    .err_ovf       (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_st(input string n, input int wp, input int lvl,
                        input logic f, input logic af, input logic r, input logic e);
    st_t s;
    s.wp = 5'(wp); s.lvl = 5'(lvl); s.full = f; s.afull = af; s.rdy = r; s.err = e; s.name = n;
    st_q.push_back(s);
  endtask

  task automatic exp_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = 4'(a); w.data = d;
    wr_q.push_back(w);
  endtask

  // Release reset and walk through the 4-cycle INIT hold with s_valid high.
  task automatic release_and_hold(input string n);
    tick();
    areset = 1'b0;
    s_valid = 1'b1;
    s_data = 32'hBAD0_0000;
    exp_st(n, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      s_data = 32'hBAD0_0000 | 32'(i);
      exp_st(n, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Back-to-back writes from an empty FIFO with rd_ptr_synced = 0.
  task automatic burst(input int n, input logic [31:0] salt);
    for (int k = 0; k < n; k++) begin
      tick();
      s_valid = 1'b1;
      s_data = salt ^ (32'(k) * 32'h0101_0101);
      exp_wr(k, s_data);
      exp_st("burst", k, k, 0, (k >= 12), 1, 0);
    end
  endtask

  // Monitor: every write and every queued status snapshot is compared here.
  always @(negedge clk) begin
    if (mem_we) begin
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%h want no write", mem_waddr, mem_wdata);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        if (mem_waddr !== w.addr || mem_wdata !== w.data) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   mem_waddr, mem_wdata, w.addr, w.data);
        end else begin
          $display("write addr=%0d data=%h ok", mem_waddr, mem_wdata);
        end
      end
    end
    if (st_q.size() != 0) begin
      st_t s;
      s = st_q.pop_front();
      checks++;
      if (wr_ptr !== s.wp || level !== s.lvl || full !== s.full || afull !== s.afull ||
          s_ready !== s.rdy || err_ovf !== s.err) begin
        failures++;
        $display("FAIL %s got wp=%0d lvl=%0d full=%b afull=%b rdy=%b err=%b want wp=%0d lvl=%0d full=%b afull=%b rdy=%b err=%b",
                 s.name, wr_ptr, level, full, afull, s_ready, err_ovf,
                 s.wp, s.lvl, s.full, s.afull, s.rdy, s.err);
      end else begin
        $display("status %s wp=%0d lvl=%0d full=%b afull=%b rdy=%b err=%b ok",
                 s.name, wr_ptr, level, full, afull, s_ready, err_ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    exp_st("reset", 0, 0, 0, 0, 0, 0);

    // INIT hold, then 16 writes: afull after the 12th, full after the 16th.
    release_and_hold("init");
    burst(16, 32'hD000_0000);
    tick();
    s_data = 32'hDEAD_0016;
    exp_st("full", 16, 16, 1, 1, 0, 0);
    tick();
    s_data = 32'hDEAD_0017;
    exp_st("no_17th", 16, 16, 1, 1, 0, 0);

    // Read advance frees one slot; one write refills it.
    tick();
    s_valid = 1'b0;
    rd_ptr_synced = 5'd1;
    exp_st("rd_step", 16, 16, 1, 1, 0, 0);
    tick();
    s_valid = 1'b1;
    s_data = 32'h1234_5678;
    exp_wr(0, 32'h1234_5678);
    exp_st("not_full", 16, 15, 0, 1, 1, 0);
    tick();
    s_valid = 1'b0;
    exp_st("refull", 17, 16, 1, 1, 0, 0);

    // Steady state at level 5, write and read each cycle, wrap 31->0.
    tick();
    rd_ptr_synced = 5'd12;
    exp_st("to_lvl5", 17, 16, 1, 1, 0, 0);
    for (int j = 0; j < 40; j++) begin
      tick();
      rd_ptr_synced = 5'((13 + j) % 32);
      s_valid = 1'b1;
      s_data = 32'h5500_0000 | 32'(j);
      exp_wr((17 + j) % 16, s_data);
      exp_st("steady", (17 + j) % 32, 5, 0, 0, 1, 0);
    end

    // Illegal distance 17: sticky error, clamp to full.
    tick();
    s_valid = 1'b0;
    rd_ptr_synced = 5'd8;
    exp_st("pre_ovf", 25, 5, 0, 0, 1, 0);
    tick();
    rd_ptr_synced = 5'd25;
    exp_st("ovf", 25, 16, 1, 1, 0, 1);
    tick();
    exp_st("ovf_sticky", 25, 0, 0, 0, 1, 1);

    // Reset clears everything; INIT hold repeats.
    tick();
    areset = 1'b1;
    rd_ptr_synced = 5'd0;
    s_valid = 1'b1;
    exp_st("reset2", 0, 0, 0, 0, 0, 0);
    release_and_hold("init2");
    burst(7, 32'hC000_0000);

    // Asynchronous reset mid-burst at wr_ptr=7: in-flight write dropped.
    tick();
    s_data = 32'hDEAD_BEEF;
    #2;
    areset = 1'b1;
    exp_st("mid_rst", 0, 0, 0, 0, 0, 0);
    release_and_hold("init3");
    burst(1, 32'hE000_0000);
    tick();
    s_valid = 1'b0;
    exp_st("after", 1, 1, 0, 0, 1, 0);

    tick();
    @(negedge clk);
    #1;
    checks++;
    if (wr_q.size() != 0 || st_q.size() != 0) begin
      failures++;
      $display("FAIL drain got wr_q=%0d st_q=%0d want 0 0", wr_q.size(), st_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
